// File: rtl/tetris_pkg.sv
// Shared Tetris piece definitions and small bag helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package tetris_pkg;

  localparam int PIECE_W    = 3;
  localparam int NUM_PIECES = 7;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_I = 3'd0;
  localparam piece_t PIECE_O = 3'd1;
  localparam piece_t PIECE_T = 3'd2;
  localparam piece_t PIECE_S = 3'd3;
  localparam piece_t PIECE_Z = 3'd4;
  localparam piece_t PIECE_J = 3'd5;
  localparam piece_t PIECE_L = 3'd6;

  // All seven pieces drawn: the bag is exhausted.
  localparam logic [NUM_PIECES-1:0] FULL_BAG = 7'h7F;

  // Rejects tolerated before the forced pick; the next reject becomes the 8th.
  localparam logic [2:0] REJ_LIMIT = 3'd7;

  // Lowest-index piece not yet drawn from the bag.
  function automatic piece_t lowest_unused(input logic [NUM_PIECES-1:0] mask);
    piece_t r;
    r = PIECE_I;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (!mask[i]) r = piece_t'(i);
    end
    return r;
  endfunction

  // Pieces still left in the bag.
  function automatic logic [2:0] bag_remaining(input logic [NUM_PIECES-1:0] mask);
    return 3'(NUM_PIECES - $countones(mask));
  endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR (right-shifting) with synchronous reset to SEED and runtime reload.
// Latency: new value visible one cycle after the advancing/loading edge.
// Backpressure: none; load has priority over en, reset over both.
module lfsr_galois #(
  parameter int         W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  // An all-zero state would lock the register, so zero is substituted by 1.
  localparam logic [W-1:0] SEED_SAFE = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  // Next value: shift right, fold the feedback mask in when a 1 falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[W-1:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ TAPS;
  end

  // State register: reset, then reload, then free-run.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_SAFE;
    end else if (load) begin
      lfsr_q <= (load_val == '0) ? W'(1) : load_val;
    end else if (en) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/piece_bag_gen.sv
// 7-bag Tetris piece generator with a head + preview FIFO fed by a Galois LFSR.
// Latency: an accepted draw is visible the cycle after its edge; pops expose preview[0] next cycle.
// Backpressure: drawing stalls while the FIFO is full and not being popped; pops on empty are ignored.
module piece_bag_gen
  import tetris_pkg::*;
#(
  parameter int                LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] TAPS          = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int                PREVIEW_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_in,
  input  logic                       next_req,
  output piece_t                     piece,
  output logic                       piece_valid,
  output logic [3*PREVIEW_DEPTH-1:0] preview,
  output logic [PREVIEW_DEPTH-1:0]   preview_valid,
  output logic [2:0]                 bag_left
);

  localparam int         Q     = PREVIEW_DEPTH + 1;
  localparam int         PTR_W = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [2:0] Q_CNT = 3'(Q);

  // Ring-buffer index arithmetic: the operand never exceeds 2*Q-1.
  function automatic logic [PTR_W-1:0] wrap_idx(input int v);
    int r;
    r = v;
    if (r >= Q) r = r - Q;
    return PTR_W'(r);
  endfunction

  logic [LFSR_W-1:0]     lfsr_val;
  logic                  lfsr_unused;

  piece_t                mem_q [Q];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [2:0]            count_q, count_d;
  logic [NUM_PIECES-1:0] used_q, used_d;
  logic [2:0]            rej_q, rej_d;

  logic                  pop;
  logic                  has_space;
  piece_t                cand;
  logic [7:0]            taken_ext;
  logic                  cand_ok;
  logic                  give_up;
  logic                  accept;
  piece_t                draw_piece;
  logic [NUM_PIECES-1:0] used_set;
  logic [PTR_W-1:0]      tail_idx;

  // The LFSR advances every cycle; a reload takes precedence inside the block.
  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (lfsr_val)
  );

  // Only the three low bits pick a candidate piece.
  assign lfsr_unused = ^lfsr_val[LFSR_W-1:3];

  // Draw decision, bag bookkeeping and FIFO pointer next-state.
  always_comb begin
    pop       = next_req && (count_q != 3'd0);
    has_space = (count_q < Q_CNT) || pop;

    // Code 7 is never a piece, so it behaves as a permanently used slot.
    cand      = lfsr_val[2:0];
    taken_ext = {1'b1, used_q};
    cand_ok   = !taken_ext[cand];
    give_up   = (rej_q == REJ_LIMIT);

    draw_piece = cand_ok ? cand : lowest_unused(used_q);
    accept     = has_space && (cand_ok || give_up);

    rej_d = rej_q;
    if (has_space) rej_d = accept ? 3'd0 : rej_q + 3'd1;

    used_set = used_q | (NUM_PIECES'(1) << draw_piece);
    used_d   = used_q;
    if (accept) used_d = (used_set == FULL_BAG) ? '0 : used_set;

    // Tail slot is computed from the pre-pop head so a full-queue pop+push
    // reuses the slot being vacated.
    tail_idx = wrap_idx(int'(head_q) + int'(count_q));
    head_d   = pop ? wrap_idx(int'(head_q) + 1) : head_q;

    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, bag mask and reject counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      count_q <= '0;
      used_q  <= '0;
      rej_q   <= '0;
      for (int i = 0; i < Q; i++) mem_q[i] <= PIECE_I;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      used_q  <= used_d;
      rej_q   <= rej_d;
      if (accept) mem_q[tail_idx] <= draw_piece;
    end
  end

  // Output view of the FIFO; empty entries read as zero.
  always_comb begin
    piece_valid   = (count_q != 3'd0);
    piece         = piece_valid ? mem_q[head_q] : PIECE_I;
    preview       = '0;
    preview_valid = '0;
    for (int k = 0; k < PREVIEW_DEPTH; k++) begin
      if (count_q > 3'(k + 1)) begin
        preview[3*k +: 3] = mem_q[wrap_idx(int'(head_q) + k + 1)];
        preview_valid[k]  = 1'b1;
      end
    end
    bag_left = bag_remaining(used_q);
  end

endmodule

// File: tb/tb_piece_bag_gen.sv
module tb_piece_bag_gen;

  localparam int DEPTH = 3;
  localparam int Q     = DEPTH + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic        next_req;
  logic [15:0] seed_in;

  logic [2:0]         piece_a, piece_b;
  logic               pv_a, pv_b;
  logic [3*DEPTH-1:0] prev_a, prev_b;
  logic [DEPTH-1:0]   prvv_a, prvv_b;
  logic [2:0]         bag_a, bag_b;

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, a list of queued pieces (index 0 = head),
  // the set of pieces already drawn from the bag, the failed-try count and
  // the pseudo-random register.
  int       m_lfsr [2];
  int       m_cnt  [2];
  int       m_q    [2][8];
  bit [6:0] m_used [2];
  int       m_rej  [2];

  int popped[$];
  int gap, maxgap;

  always #5 clk = ~clk;

  piece_bag_gen #(
    .LFSR_W(16), .TAPS(16'hB400), .SEED(16'hACE1), .PREVIEW_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .next_req(next_req), .piece(piece_a), .piece_valid(pv_a),
    .preview(prev_a), .preview_valid(prvv_a), .bag_left(bag_a)
  );

  piece_bag_gen #(
    .LFSR_W(16), .TAPS(16'hB400), .SEED(16'h0000), .PREVIEW_DEPTH(DEPTH)
  ) dut_z (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .next_req(next_req), .piece(piece_b), .piece_valid(pv_b),
    .preview(prev_b), .preview_valid(prvv_b), .bag_left(bag_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Galois form.
  function automatic int prng_step(input int v);
    if (v % 2 == 1) return (v / 2) ^ 'hB400;
    return v / 2;
  endfunction

  // One clock edge of the generator, straight from the behavioural rules.
  task automatic model_edge(input int i, input int seed0);
    int cand, take;
    bit pop;
    if (rst) begin
      m_lfsr[i] = (seed0 == 0) ? 1 : seed0;
      m_used[i] = '0;
      m_cnt[i]  = 0;
      m_rej[i]  = 0;
      return;
    end
    take = -1;
    pop  = next_req && (m_cnt[i] > 0);
    cand = m_lfsr[i] % 8;
    if (m_cnt[i] < Q || pop) begin
      if (cand < 7 && !m_used[i][cand]) take = cand;
      else if (m_rej[i] == 7) begin
        for (int p = 6; p >= 0; p--) if (!m_used[i][p]) take = p;
      end else m_rej[i]++;
    end
    if (pop) begin
      for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
      m_cnt[i]--;
    end
    if (take >= 0) begin
      m_q[i][m_cnt[i]] = take;
      m_cnt[i]++;
      m_used[i][take] = 1'b1;
      m_rej[i] = 0;
      if (m_used[i] == 7'h7F) m_used[i] = '0;
    end
    if (seed_load) m_lfsr[i] = (seed_in == 0) ? 1 : int'(seed_in);
    else           m_lfsr[i] = prng_step(m_lfsr[i]);
  endtask

  task automatic check_inst(input int i, input logic [2:0] pc, input logic pv,
                            input logic [3*DEPTH-1:0] pr, input logic [DEPTH-1:0] prv,
                            input logic [2:0] bl);
    logic [3*DEPTH-1:0] ep;
    logic [DEPTH-1:0]   ev;
    ep = '0;
    ev = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (m_cnt[i] > k + 1) begin
        ep[3*k +: 3] = 3'(m_q[i][k+1]);
        ev[k] = 1'b1;
      end
    end
    chk($sformatf("piece[%0d]", i), pc, (m_cnt[i] > 0) ? m_q[i][0] : 0);
    chk($sformatf("piece_valid[%0d]", i), pv, m_cnt[i] > 0);
    chk($sformatf("preview[%0d]", i), pr, ep);
    chk($sformatf("preview_valid[%0d]", i), prv, ev);
    chk($sformatf("bag_left[%0d]", i), bl, 7 - $countones(m_used[i]));
  endtask

  task automatic tick();
    if (pv_a && next_req && !rst) popped.push_back(int'(piece_a));
    model_edge(0, 'hACE1);
    model_edge(1, 0);
    @(posedge clk);
    #1;
    check_inst(0, piece_a, pv_a, prev_a, prvv_a, bag_a);
    check_inst(1, piece_b, pv_b, prev_b, prvv_b, bag_b);
    chk("count_bound", dut.count_q <= 3'(Q), 1);
    if (pv_a) gap = 0;
    else      gap++;
    if (gap > maxgap) maxgap = gap;
  endtask

  task automatic check_bags(input string tag, input int groups);
    bit [7:0] seen;
    int n7;
    n7 = 0;
    for (int g = 0; g < groups; g++) begin
      seen = '0;
      for (int k = 0; k < 7; k++) begin
        if (popped[g*7+k] > 6) n7++;
        else seen[popped[g*7+k]] = 1'b1;
      end
      chk($sformatf("%s_perm%0d", tag, g), seen, 8'h7F);
    end
    chk($sformatf("%s_no_code7", tag), n7, 0);
  endtask

  initial begin
    int seen, first, n, exp_fb;

    rst = 1'b1; seed_load = 1'b0; next_req = 1'b0; seed_in = '0;
    gap = 0; maxgap = 0;
    repeat (2) tick();
    chk("rst_piece_valid", pv_a, 0);
    chk("rst_bag_left", bag_a, 7);
    chk("rst_preview", prev_a, 0);
    chk("rst_preview_valid", prvv_a, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    chk("rst_lfsr_zero_seed", dut_z.u_lfsr.q, 1);

    // Fill without popping.
    rst = 1'b0;
    repeat (40) tick();
    chk("fill_valid", pv_a, 1);
    chk("fill_preview_valid", prvv_a, 3'b111);
    chk("fill_bag_left", bag_a, 3);
    seen = 0;
    seen |= 1 << piece_a;
    for (int k = 0; k < DEPTH; k++) seen |= 1 << prev_a[3*k +: 3];
    chk("fill_distinct", $countones(seen), 4);
    chk("fill_in_range", seen & 'h80, 0);

    // Reset with pop held: empty-queue pops are harmless, then stream 70 pieces.
    rst = 1'b1; next_req = 1'b1;
    tick();
    rst = 1'b0;
    popped.delete();
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (pv_a && first < 0) first = c;
    end
    chk("first_valid_in_window", first >= 1, 1);
    gap = 0; maxgap = 0;
    n = 0;
    while (popped.size() < 70 && n < 1000) begin
      tick();
      n++;
    end
    chk("stream_pops", popped.size(), 70);
    if (popped.size() == 70) check_bags("stream", 10);
    chk("stream_max_gap", maxgap <= 8, 1);

    // Forced fallback: seed with bits [9:0] all ones gives candidate 7 eight times.
    next_req = 1'b0;
    repeat (40) tick();
    chk("pre_fb_full", prvv_a, 3'b111);
    seed_in = 16'h03FF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("fb_lfsr_loaded", dut.u_lfsr.q, 16'h03FF);
    chk("fb_queue_untouched", prvv_a, 3'b111);
    next_req = 1'b1;
    repeat (7) tick();
    chk("fb_rej_count", dut.rej_q, 7);
    chk("fb_drained", pv_a, 0);
    exp_fb = -1;
    for (int p = 6; p >= 0; p--) if (!m_used[0][p]) exp_fb = p;
    tick();
    chk("fb_piece_valid", pv_a, 1);
    chk("fb_lowest_unused", piece_a, exp_fb);
    chk("fb_rej_clear", dut.rej_q, 0);

    // Mid-bag reset, with a simultaneous reseed that must lose.
    n = 0;
    while (bag_a != 3'd4 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_bag_reached", bag_a, 4);
    rst = 1'b1; seed_load = 1'b1; seed_in = 16'h1234; next_req = 1'b0;
    tick();
    chk("midrst_bag_left", bag_a, 7);
    chk("midrst_piece_valid", pv_a, 0);
    chk("midrst_lfsr", dut.u_lfsr.q, 16'hACE1);
    rst = 1'b0; seed_load = 1'b0; next_req = 1'b1;
    popped.delete();
    n = 0;
    while (popped.size() < 7 && n < 200) begin
      tick();
      n++;
    end
    chk("midrst_pops", popped.size(), 7);
    if (popped.size() == 7) check_bags("midrst", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
